exception_ctrl: RTL
===================

# exception_ctrl

Exception controller for the single-cycle LEGv8 core; consumes the exception signals the main decoder produces (EStatus, NotAnInstr, ERet) plus the external interrupt line, and produces the PC redirect, flush, status registers and interrupt acknowledge. It sits beside the fetch/PC logic: it answers the decoder's exception requests and ERET returns, and owns ELR/ESR, which MRS reads.

## Interface
- N, 64, PC/address width.
- EXC_VECTOR, 64'hD8, handler entry address driven on ExcAddr when an exception is taken.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- InstrValid  in  1  decode-stage instruction is valid this cycle.
- PC_dec  in  N  PC of the instruction currently decoded.
- NotAnInstr  in  1  decoder flags invalid opcode.
- EStatus  in  4  decoder status code (4'b0010 = invalid opcode).
- ERet  in  1  decoder flags ERET.
- ExtIRQ  in  1  external interrupt request, level-sensitive, asynchronous to instruction flow.
- Exc  out  1  one-cycle pulse: take exception, flush, PC <= ExcAddr.
- ExcAddr  out  N  constant EXC_VECTOR.
- ERetTaken  out  1  one-cycle pulse: PC <= RetAddr.
- RetAddr  out  N  equals ELR.
- ELR  out  N  exception link register (MRS source).
- ESR  out  4  exception syndrome register (MRS source).
- ExtIAck  out  1  one-cycle acknowledge of a taken external IRQ.
- InHandler  out  1  high in HANDLER state.
- Halt  out  1  fatal nested exception; sticky until reset.

## Operation
- States: IDLE, TAKE, HANDLER, RET, HALT. Reset -> IDLE.
- irq_pend register: set on clk when ExtIRQ=1 and state is IDLE/HANDLER/TAKE/RET; cleared in the TAKE cycle of an IRQ-caused exception (set has priority only if ExtIRQ still high after clear cycle; clear wins in that cycle).
- IDLE, InstrValid=1:
  - NotAnInstr=1 -> ESR<=EStatus, ELR<=PC_dec, cause<=INSTR, go TAKE.
  - else irq_pend=1 -> ESR<=4'b0001, ELR<=PC_dec (instruction squashed, re-executed after return), cause<=IRQ, go TAKE.
  - else ERet=1 -> ignored (no redirect, stay IDLE).
- Priority on simultaneous events: invalid opcode > IRQ; losing IRQ stays pending.
- InstrValid=0 -> no transition in any state except TAKE/RET (unconditional).
- TAKE: Exc=1; ExtIAck=1 iff cause=IRQ; inputs ignored; -> HANDLER.
- HANDLER (IRQs masked, irq_pend still accumulates), InstrValid=1:
  - NotAnInstr=1 -> HALT; ESR/ELR unchanged.
  - else ERet=1 -> RET.
- RET: ERetTaken=1, RetAddr=ELR; inputs ignored; -> IDLE. Pending IRQ may be taken on the next IDLE cycle.
- HALT: Halt=1, all pulses 0, exits only on reset.
- ESR/ELR change only on IDLE->TAKE; hold in all other states.

## Timing
- Reset values: state IDLE, irq_pend 0, ELR 0, ESR 0, Exc 0, ERetTaken 0, ExtIAck 0, InHandler 0, Halt 0; ExcAddr = EXC_VECTOR, RetAddr = 0.
- Detection cycle t (IDLE, registered at edge ending t): Exc, ExtIAck high during t+1 only; ELR/ESR visible from t+1; InHandler high from t+2.
- ExtIRQ rise in cycle t -> irq_pend=1 at t+1 -> earliest Exc at t+2.
- ERET detected in HANDLER at t -> ERetTaken high in t+1 only, InHandler low from t+1.
- All outputs registered or derived only from state/registers; no combinational input-to-output path.
- Reset asserted in any state (incl. TAKE, RET, HALT): next cycle all registers at reset values; pulses in flight are dropped.

## Configuration
- EXC_EXTIRQ_EN defined: external interrupt path as described.
- Not defined: irq_pend, ExtIAck logic removed; ExtIAck tied 0; ExtIRQ ignored; only invalid-opcode exceptions taken; ESR never 4'b0001.

## Test plan
- Invalid opcode: IDLE, InstrValid=1, NotAnInstr=1, EStatus=4'b0010, PC_dec=64'h40 -> next cycle Exc=1, ExcAddr=64'hD8, ESR=4'b0010, ELR=64'h40; following cycle InHandler=1.
- ERET return: in HANDLER, ERet=1 -> next cycle ERetTaken=1, RetAddr=64'h40, then IDLE, InHandler=0.
- IRQ: ExtIRQ pulse 1 cycle at t, PC_dec=64'h100, InstrValid=1 -> Exc=1 and ExtIAck=1 at t+2, ESR=4'b0001, ELR=64'h100; second IRQ during HANDLER taken only after RET.
- Simultaneous NotAnInstr and pending IRQ -> ESR=4'b0010 first; after ERET, IRQ taken with ESR=4'b0001.
- Nested fault: NotAnInstr in HANDLER -> Halt=1 sticky, no Exc; reset -> all outputs zero, state IDLE.
- Without EXC_EXTIRQ_EN: ExtIRQ held high 20 cycles -> no Exc, ExtIAck always 0.

Source files
------------

// File: rtl/exception_ctrl.sv
// exception_ctrl
// Exception controller for the single-cycle LEGv8 core. It takes invalid-opcode
// exceptions (and, optionally, external interrupts), redirects the PC to the
// handler vector, and owns ELR/ESR. It also returns from the handler on ERET.
//
// Optional feature: define EXC_EXTIRQ_EN to enable the external interrupt path
// (irq_pend register, ExtIAck). Without it, ExtIRQ is ignored and ExtIAck is 0.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   InstrValid, PC_dec   decode-stage valid flag and PC
//   NotAnInstr, EStatus  invalid-opcode flag and status code from the decoder
//   ERet                 ERET flag from the decoder
//   ExtIRQ               level-sensitive external interrupt request
//   Exc, ExcAddr         one-cycle take-exception pulse, handler vector
//   ERetTaken, RetAddr   one-cycle return pulse, return address (= ELR)
//   ELR, ESR             exception link / syndrome registers
//   ExtIAck              one-cycle interrupt acknowledge
//   InHandler, Halt      handler-active flag, sticky fatal-nesting flag
//   dbg_state_o          current FSM state, for observation only
//
// Handshake: there is no back-pressure. A decoder request counts only in a
// cycle where InstrValid=1 and is sampled on the rising edge that ends that
// cycle. Every output is a function of registered state only.
module exception_ctrl #(
  parameter int          N          = 64,
  parameter logic [N-1:0] EXC_VECTOR = N'('hD8)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         InstrValid,
  input  logic [N-1:0] PC_dec,
  input  logic         NotAnInstr,
  input  logic [3:0]   EStatus,
  input  logic         ERet,
  input  logic         ExtIRQ,
  output logic         Exc,
  output logic [N-1:0] ExcAddr,
  output logic         ERetTaken,
  output logic [N-1:0] RetAddr,
  output logic [N-1:0] ELR,
  output logic [3:0]   ESR,
  output logic         ExtIAck,
  output logic         InHandler,
  output logic         Halt,
  output logic [2:0]   dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TAKE    = 3'd1,
    S_HANDLER = 3'd2,
    S_RET     = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] elr_q, elr_d;
  logic [3:0]   esr_q, esr_d;

`ifdef EXC_EXTIRQ_EN
  logic irq_pend_q, irq_pend_d;
  // 1 = the exception in flight was caused by an interrupt
  logic cause_irq_q, cause_irq_d;
`else
  logic unused_extirq;
  assign unused_extirq = ExtIRQ;
`endif

  always_comb begin
    state_d = state_q;
    elr_d   = elr_q;
    esr_d   = esr_q;
`ifdef EXC_EXTIRQ_EN
    cause_irq_d = cause_irq_q;
    irq_pend_d  = irq_pend_q;
    if (ExtIRQ && state_q != S_HALT) irq_pend_d = 1'b1;
    // Acknowledging the interrupt consumes the pending flag; clear beats set.
    if (state_q == S_TAKE && cause_irq_q) irq_pend_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (InstrValid) begin
          if (NotAnInstr) begin
            esr_d   = EStatus;
            elr_d   = PC_dec;
            state_d = S_TAKE;
`ifdef EXC_EXTIRQ_EN
            cause_irq_d = 1'b0;
          end else if (irq_pend_q) begin
            // The decoded instruction is squashed and re-executed on return.
            esr_d       = 4'b0001;
            elr_d       = PC_dec;
            cause_irq_d = 1'b1;
            state_d     = S_TAKE;
`endif
          end
          // ERET outside a handler is ignored.
        end
      end
      S_TAKE:    state_d = S_HANDLER;
      S_HANDLER: begin
        if (InstrValid) begin
          if (NotAnInstr)  state_d = S_HALT;
          else if (ERet)   state_d = S_RET;
        end
      end
      S_RET:     state_d = S_IDLE;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      elr_q   <= '0;
      esr_q   <= '0;
`ifdef EXC_EXTIRQ_EN
      irq_pend_q  <= 1'b0;
      cause_irq_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      elr_q   <= elr_d;
      esr_q   <= esr_d;
`ifdef EXC_EXTIRQ_EN
      irq_pend_q  <= irq_pend_d;
      cause_irq_q <= cause_irq_d;
`endif
    end
  end

  assign Exc         = (state_q == S_TAKE);
  assign ExcAddr     = EXC_VECTOR;
  assign ERetTaken   = (state_q == S_RET);
  assign RetAddr     = elr_q;
  assign ELR         = elr_q;
  assign ESR         = esr_q;
  assign InHandler   = (state_q == S_HANDLER);
  assign Halt        = (state_q == S_HALT);
  assign dbg_state_o = state_q;
`ifdef EXC_EXTIRQ_EN
  assign ExtIAck     = (state_q == S_TAKE) && cause_irq_q;
`else
  assign ExtIAck     = 1'b0;
`endif

endmodule
